// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 8-bit products per job under a start/valid/ack handshake.
// Build with PRODUCT_ACCUMULATOR_SATURATE_EN defined to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ack,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [4:0] LAST_TERM = 5'(N_TERMS - 1);

  state_t         state;
  logic [4:0]     count;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] sum;
  logic           carry;
  logic           xfer;

  always_comb begin
    prod_ext       = '0;
    prod_ext[7:0]  = prod_in;
    sum            = {1'b0, acc_out} + prod_ext;
    carry          = sum[ACC_W];
    xfer           = prod_ready && prod_valid;
  end

  // Handshake outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_out    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      acc_valid  <= 1'b0;
      prod_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            acc_out    <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            prod_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ACCUM: begin
          if (xfer) begin
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            // Once clamped, the sum stays at full scale for the rest of the job.
            if (carry || overflow) acc_out <= '1;
            else                   acc_out <= sum[ACC_W-1:0];
`else
            acc_out <= sum[ACC_W-1:0];
`endif
            if (carry) overflow <= 1'b1;
            count <= count + 5'd1;
            if (count == LAST_TERM) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              acc_valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ack) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          acc_valid  <= 1'b0;
          prod_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
